// File: rtl/pipe_stage_regs_pkg.sv
// Shared constants for the pipeline-register bank: MIPS opcode/funct fields,
// Tnew encodings, the bubble word and the Tnew encoder.
package pipe_stage_regs_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  // Cycles from E entry until the result exists; sll $0 (the bubble word) is R-type.
  function automatic logic [1:0] tnew_of(input logic [31:0] ir);
    logic [1:0] t;
    t = TNEW_0;
    case (ir[31:26])
      OP_LW:          t = TNEW_2;
      OP_R:           t = (ir[5:0] == FN_JR) ? TNEW_0 : TNEW_1;
      OP_ORI, OP_LUI: t = TNEW_1;
      default:        t = TNEW_0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pipe_stage_regs_if.sv
// Signal bundle between the stall controller/datapath (master) and the
// pipeline-register bank (slave).
interface pipe_stage_regs_if #(parameter int CNT_W = 16);
  logic              enPC, enD, FlushE;
  logic [31:0]       NPC, InstrF, RD1D, RD2D, EXTD, ALUE, RTE_fwd;
  logic [31:0]       PCF, IRD, PC4D;
  logic [31:0]       IRE, PC4E, RSE, RTE, EXTE;
  logic [31:0]       IRM, PC4M, ALUM, RTM;
  logic              validD, validE, validM;
  logic [1:0]        TnewE, TnewM;
  logic [CNT_W-1:0]  stall_cnt;
  logic              ctl_err;

  modport master (
    output enPC, enD, FlushE, NPC, InstrF, RD1D, RD2D, EXTD, ALUE, RTE_fwd,
    input  PCF, IRD, PC4D, IRE, PC4E, RSE, RTE, EXTE, IRM, PC4M, ALUM, RTM,
    input  validD, validE, validM, TnewE, TnewM, stall_cnt, ctl_err
  );

  modport slave (
    input  enPC, enD, FlushE, NPC, InstrF, RD1D, RD2D, EXTD, ALUE, RTE_fwd,
    output PCF, IRD, PC4D, IRE, PC4E, RSE, RTE, EXTE, IRM, PC4M, ALUM, RTM,
    output validD, validE, validM, TnewE, TnewM, stall_cnt, ctl_err
  );
endinterface

// File: rtl/pipe_stage_regs_pipe_reg.sv
// Single pipeline field: async reset to RST_VAL, flush to zero wins over load enable.
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= RST_VAL;
    else if (flush) q <= '0;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, F/D, D/E and E/M registers of the 5-stage core, with Tnew tagging,
// saturating stall counter and sticky enable-mismatch flag.
module pipe_stage_regs
  import pipe_stage_regs_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  pipe_stage_regs_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       tnew_e_d, tnew_m_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             ctl_err_q;

  assign tnew_e_d = tnew_of(bus.IRD);
  assign tnew_m_d = (bus.TnewE == TNEW_0) ? TNEW_0 : bus.TnewE - 2'd1;

  // PC
  pipe_reg #(.W(32), .RST_VAL(PC_RESET)) u_pcf (.clk, .reset, .en(bus.enPC), .flush(1'b0), .d(bus.NPC), .q(bus.PCF));

  // F/D: holds when enD is low
  pipe_reg #(.W(32)) u_ird    (.clk, .reset, .en(bus.enD), .flush(1'b0), .d(bus.InstrF),        .q(bus.IRD));
  pipe_reg #(.W(32)) u_pc4d   (.clk, .reset, .en(bus.enD), .flush(1'b0), .d(bus.PCF + 32'd4),   .q(bus.PC4D));
  pipe_reg #(.W(1))  u_validd (.clk, .reset, .en(bus.enD), .flush(1'b0), .d(1'b1),              .q(bus.validD));

  // D/E: no hold path, loads or flushes every cycle
  pipe_reg #(.W(32)) u_ire    (.clk, .reset, .en(1'b1), .flush(bus.FlushE), .d(bus.IRD),    .q(bus.IRE));
  pipe_reg #(.W(32)) u_pc4e   (.clk, .reset, .en(1'b1), .flush(bus.FlushE), .d(bus.PC4D),   .q(bus.PC4E));
  pipe_reg #(.W(32)) u_rse    (.clk, .reset, .en(1'b1), .flush(bus.FlushE), .d(bus.RD1D),   .q(bus.RSE));
  pipe_reg #(.W(32)) u_rte    (.clk, .reset, .en(1'b1), .flush(bus.FlushE), .d(bus.RD2D),   .q(bus.RTE));
  pipe_reg #(.W(32)) u_exte   (.clk, .reset, .en(1'b1), .flush(bus.FlushE), .d(bus.EXTD),   .q(bus.EXTE));
  pipe_reg #(.W(1))  u_valide (.clk, .reset, .en(1'b1), .flush(bus.FlushE), .d(bus.validD), .q(bus.validE));
  pipe_reg #(.W(2))  u_tnewe  (.clk, .reset, .en(1'b1), .flush(bus.FlushE), .d(tnew_e_d),   .q(bus.TnewE));

  // E/M: always advances, so E drains into M even during a stall
  pipe_reg #(.W(32)) u_irm    (.clk, .reset, .en(1'b1), .flush(1'b0), .d(bus.IRE),     .q(bus.IRM));
  pipe_reg #(.W(32)) u_pc4m   (.clk, .reset, .en(1'b1), .flush(1'b0), .d(bus.PC4E),    .q(bus.PC4M));
  pipe_reg #(.W(32)) u_alum   (.clk, .reset, .en(1'b1), .flush(1'b0), .d(bus.ALUE),    .q(bus.ALUM));
  pipe_reg #(.W(32)) u_rtm    (.clk, .reset, .en(1'b1), .flush(1'b0), .d(bus.RTE_fwd), .q(bus.RTM));
  pipe_reg #(.W(1))  u_validm (.clk, .reset, .en(1'b1), .flush(1'b0), .d(bus.validE),  .q(bus.validM));
  pipe_reg #(.W(2))  u_tnewm  (.clk, .reset, .en(1'b1), .flush(1'b0), .d(tnew_m_d),    .q(bus.TnewM));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      ctl_err_q   <= 1'b0;
    end else begin
      if (!bus.enPC && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (bus.enPC != bus.enD)            ctl_err_q   <= 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.ctl_err   = ctl_err_q;

endmodule
